// File: rtl/alarm_time_setter.sv
// alarm_time_setter: push-button editor for the alarm time.
// Four raw buttons are synchronized and debounced into one-cycle press events.
// An IDLE / SET_HR / SET_MIN state machine edits shadow hour/minute registers.
// Leaving SET_MIN with mode commits the shadow atomically. Cancel or an idle
// timeout discards the shadow. BCD digits follow the shadow while editing and
// the committed time otherwise.
// Optional feature macro: AUTO_REPEAT_EN. When defined, holding increment or
// decrement steps the value repeatedly (REPEAT_DELAY, then every REPEAT_CYCLES).
module alarm_time_setter #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1000000000,
  parameter logic [31:0] BLINK_CYCLES    = 32'd25000000,
  parameter logic [5:0]  RST_HR          = 6'd12,
  parameter logic [5:0]  RST_MIN         = 6'd0
`ifdef AUTO_REPEAT_EN
  ,
  parameter logic [31:0] REPEAT_DELAY    = 32'd25000000,
  parameter logic [31:0] REPEAT_CYCLES   = 32'd5000000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  output logic [5:0] a_hr,
  output logic [5:0] a_min,
  output logic       a_update,
  output logic       editing,
  output logic       field,
  output logic       blink,
  output logic [3:0] hr1,
  output logic [3:0] hr2,
  output logic [3:0] min1,
  output logic [3:0] min2
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SET_HR  = 2'd1,
    S_SET_MIN = 2'd2
  } state_t;

  // Button bit positions
  localparam int B_MODE   = 0;
  localparam int B_INC    = 1;
  localparam int B_DEC    = 2;
  localparam int B_CANCEL = 3;

  // Input path
  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  r_level;
  logic [3:0]  r_press;
  logic [15:0] r_db_cnt [4];
  logic        w_any_press;

  // Control
  state_t      r_state;
  state_t      w_state_next;
  logic        w_editing;
  logic        w_load;
  logic        w_commit;
  logic        w_step_up;
  logic        w_step_dn;
  logic        w_timeout;
  logic        w_rep_step;
  logic        w_rep_up;

  // Datapath
  logic [5:0]  r_sh_hr;
  logic [5:0]  r_sh_min;
  logic [5:0]  r_a_hr;
  logic [5:0]  r_a_min;
  logic        r_a_update;
  logic [31:0] r_to_cnt;
  logic [31:0] r_blink_cnt;
  logic        r_blink;
  logic [5:0]  w_hr_up;
  logic [5:0]  w_hr_dn;
  logic [5:0]  w_min_up;
  logic [5:0]  w_min_dn;
  logic [5:0]  w_disp_hr;
  logic [5:0]  w_disp_min;

  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] bcd_units(input logic [5:0] v);
    logic [5:0] u;
    u = v % 6'd10;
    return u[3:0];
  endfunction

  // Synchronize and debounce each button; emit a pulse on the accepted rising level
  // NOTE: the counter array is reset element by element; it is a small register
  // bank, not a RAM, so a full async reset is cheap and keeps startup deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_press <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments here let r_sync2 sample the old r_sync1,
      // forming a genuine two-flop synchronizer rather than a single wire.
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] != r_level[i]) begin
          if (r_db_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
            r_level[i]  <= r_sync2[i];
            r_press[i]  <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_any_press = |r_press;
  assign w_editing   = (r_state != S_IDLE);

  // Idle timer for edit states; any press or repeat step restarts it, saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (!w_editing || w_any_press || w_rep_step) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TIMEOUT_CYCLES - 32'd1) begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end
  end

  assign w_timeout = w_editing && (r_to_cnt == TIMEOUT_CYCLES - 32'd1)
                     && !w_any_press && !w_rep_step;

`ifdef AUTO_REPEAT_EN
  logic [31:0] r_rep_cnt;
  logic        r_rep_phase;
  logic        w_rep_hold;

  assign w_rep_hold = w_editing && (r_level[B_INC] || r_level[B_DEC]);
  assign w_rep_up   = r_level[B_INC];
  assign w_rep_step = w_rep_hold && !w_any_press &&
                      (r_rep_phase ? (r_rep_cnt == REPEAT_CYCLES - 32'd1)
                                   : (r_rep_cnt == REPEAT_DELAY - 32'd1));

  // Hold timer: initial delay phase, then periodic phase; release or state change restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if (!w_rep_hold || w_any_press || (w_state_next != r_state)) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_rep_step) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b1;
    end else begin
      r_rep_cnt   <= r_rep_cnt + 32'd1;
    end
  end
`else
  assign w_rep_step = 1'b0;
  assign w_rep_up   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and one action per cycle: cancel > mode > inc > dec > repeat > timeout
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_load       = 1'b0;
    w_commit     = 1'b0;
    w_step_up    = 1'b0;
    w_step_dn    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_press[B_MODE]) begin
          w_load       = 1'b1;
          w_state_next = S_SET_HR;
        end
      end
      S_SET_HR, S_SET_MIN: begin
        if (r_press[B_CANCEL]) begin
          w_state_next = S_IDLE;
        end else if (r_press[B_MODE]) begin
          if (r_state == S_SET_HR) begin
            w_state_next = S_SET_MIN;
          end else begin
            w_state_next = S_IDLE;
            w_commit     = 1'b1;
          end
        end else if (r_press[B_INC]) begin
          w_step_up = 1'b1;
        end else if (r_press[B_DEC]) begin
          w_step_dn = 1'b1;
        end else if (w_rep_step) begin
          w_step_up = w_rep_up;
          w_step_dn = !w_rep_up;
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_hr_up  = (r_sh_hr  == 6'd23) ? 6'd0  : r_sh_hr  + 6'd1;
  assign w_hr_dn  = (r_sh_hr  == 6'd0)  ? 6'd23 : r_sh_hr  - 6'd1;
  assign w_min_up = (r_sh_min == 6'd59) ? 6'd0  : r_sh_min + 6'd1;
  assign w_min_dn = (r_sh_min == 6'd0)  ? 6'd59 : r_sh_min - 6'd1;

  // Shadow registers: load on entry, step the field selected by the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_hr  <= RST_HR;
      r_sh_min <= RST_MIN;
    end else if (w_load) begin
      r_sh_hr  <= r_a_hr;
      r_sh_min <= r_a_min;
    end else if (w_step_up) begin
      if (r_state == S_SET_HR) r_sh_hr  <= w_hr_up;
      else                     r_sh_min <= w_min_up;
    end else if (w_step_dn) begin
      if (r_state == S_SET_HR) r_sh_hr  <= w_hr_dn;
      else                     r_sh_min <= w_min_dn;
    end
  end

  // Committed alarm time, changed only by commit, with a matching one-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_hr     <= RST_HR;
      r_a_min    <= RST_MIN;
      r_a_update <= 1'b0;
    end else begin
      r_a_update <= w_commit;
      if (w_commit) begin
        r_a_hr  <= r_sh_hr;
        r_a_min <= r_sh_min;
      end
    end
  end

  // Blink generator: restarts high on SET_HR entry and field change, low in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (w_state_next == S_IDLE) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (w_state_next != r_state) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (r_blink_cnt == BLINK_CYCLES - 32'd1) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + 32'd1;
    end
  end

  assign w_disp_hr  = w_editing ? r_sh_hr  : r_a_hr;
  assign w_disp_min = w_editing ? r_sh_min : r_a_min;

  assign a_hr     = r_a_hr;
  assign a_min    = r_a_min;
  assign a_update = r_a_update;
  assign editing  = w_editing;
  assign field    = (r_state == S_SET_MIN);
  assign blink    = r_blink;
  assign hr1      = bcd_tens(w_disp_hr);
  assign hr2      = bcd_units(w_disp_hr);
  assign min1     = bcd_tens(w_disp_min);
  assign min2     = bcd_units(w_disp_min);

endmodule

// File: doc/alarm_time_setter.md
Name: alarm_time_setter

Overview:
Button-driven writer for the alarm time consumed by the alarm clock comparator (a_hr/a_min inputs). Debounces four push-buttons and runs an edit state machine over shadow hour/minute registers. Commits the new alarm time atomically, or discards it on cancel or timeout. Drives BCD digits of the value being edited, plus a blink flag, for the shared 4-digit display.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, cycles a raw button level must be stable before it is accepted (sim: 4)
TIMEOUT_CYCLES, 32'd1000000000, idle cycles in an edit state before auto-cancel (sim: 200)
BLINK_CYCLES, 32'd25000000, half-period of the blink flag in edit states (sim: 8)
RST_HR, 6'd12, committed hour after reset
RST_MIN, 6'd0, committed minute after reset

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
btn  in  4  raw buttons: [0] mode/next, [1] increment, [2] decrement, [3] cancel
a_hr  out  6  committed alarm hour, 0..23
a_min  out  6  committed alarm minute, 0..59
a_update  out  1  one-cycle pulse when a_hr/a_min change by commit
editing  out  1  high in SET_HR or SET_MIN
field  out  1  0 = hour being edited, 1 = minute being edited
blink  out  1  toggles every BLINK_CYCLES while editing; 0 otherwise
hr1, hr2, min1, min2  out  4 each  BCD tens/units of shadow time while editing, of committed time otherwise

Behaviour:
- Reset (async, rst_n=0): a_hr=RST_HR, a_min=RST_MIN, shadow regs equal committed, state IDLE, a_update=0, editing=0, field=0, blink=0, all debounce counters 0, all debounced levels 0. Digits show RST_HR:RST_MIN.
- Input path: per button, a 2-flop synchronizer, then a debounce counter. Counter resets on any change of the synced level. Debounced level updates when the count reaches DEBOUNCE_CYCLES-1. A press event is a one-cycle pulse on the debounced 0->1 edge. Latency from a stable raw edge to the pulse is 2 + DEBOUNCE_CYCLES cycles. Releases generate no event.
- FSM states: IDLE, SET_HR, SET_MIN.
  - IDLE + mode: copy committed time into shadow, go to SET_HR.
  - SET_HR + mode: go to SET_MIN.
  - SET_MIN + mode: commit. a_hr/a_min take the shadow values on the next edge, a_update pulses for 1 cycle in that same cycle, state returns to IDLE.
  - SET_* + cancel, or timeout: return to IDLE with no commit and no a_update. Shadow is discarded.
  - IDLE ignores increment, decrement and cancel.
- Editing arithmetic: increment/decrement act on the field selected by the state.
  - Hour wraps 23->0 and 0->23.
  - Minute wraps 59->0 and 0->59.
  - Fields are independent: a minute wrap never carries into the hour.
- Simultaneous events, priority: cancel > mode > increment > decrement. Exactly one action is taken per cycle.
- Timeout counter: cleared on entry to an edit state and on any press event. Saturates; fires when it reaches TIMEOUT_CYCLES-1 in an edit state.
- blink: counter cleared on entry to SET_HR and on each field change. blink starts at 1 and is forced to 0 in IDLE.
- BCD: tens = value/10, units = value%10, computed combinationally from a registered source. Values above 59 cannot occur.
- No commit ever produces an out-of-range value. a_hr/a_min change only via commit or reset.

Optional Feature:
AUTO_REPEAT_EN
- Defined: holding increment or decrement in an edit state generates one extra step after REPEAT_DELAY cycles (parameter, default 32'd25000000, sim 20), then one step every REPEAT_CYCLES (default 32'd5000000, sim 5) while held. Repeats reset the timeout. Release or state change stops the repeat immediately.
- Undefined: only press edges step the value; REPEAT_DELAY and REPEAT_CYCLES are absent.

Test Plan:
- Reset release with btn=0 -> a_hr=12, a_min=0, digits 1,2,0,0, editing=0, a_update=0.
- Sequence mode, 3x increment, mode, 2x decrement, mode (each press held more than DEBOUNCE_CYCLES) -> a_hr=15, a_min=58, exactly one a_update pulse, state back in IDLE.
- Hour at 23 plus increment -> 0. Minute at 0 plus decrement -> 59. Minute 59 plus increment -> 0 with hour unchanged.
- Edit to 07:30, then press cancel in SET_MIN -> a_hr/a_min keep their prior value, no a_update, digits revert to committed time.
- Enter SET_HR with no further presses -> auto-cancel after TIMEOUT_CYCLES, editing=0, no commit. Glitch on btn[1] shorter than DEBOUNCE_CYCLES -> no step.
- Mode and cancel presses in the same cycle while in SET_HR -> cancel wins, IDLE, no commit. With AUTO_REPEAT_EN, holding increment for REPEAT_DELAY+3*REPEAT_CYCLES -> hour advances by 5.
